// File: rtl/vector_execute_pipe_pkg.sv
// Shared vector-execute definitions: opcode enum, default lane type and
// small opcode classification helpers used by execute and decode.
package vec_exec_pkg;

    localparam int OP_W   = 4;
    localparam int LANE_W = 32;

    typedef logic signed [LANE_W-1:0] lane_t;

    typedef enum logic [OP_W-1:0] {
        VADD    = 4'h0,
        VSUB    = 4'h1,
        VMUL    = 4'h2,
        VADDS   = 4'h3,
        VADDI   = 4'h4,
        VMAX    = 4'h5,
        VMIN    = 4'h6,
        VSPLAT  = 4'h7,
        VREDSUM = 4'h8,
        VDOT    = 4'h9,
        VEXT    = 4'hA,
        VACC    = 4'hB,
        VACCCLR = 4'hC
    } vec_op_e;

    // True for every opcode the execute stage implements; 4'hD..4'hF are illegal.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op <= VACCCLR;
    endfunction

endpackage

// File: rtl/vector_execute_pipe_if.sv
// Issue/result bundle between register read, the execute stage and writeback.
// master = issuing/consuming side, slave = the execute stage.
interface vector_execute_pipe_if #(
    parameter int LANES   = 4,
    parameter int DATA_W  = 32,
    parameter int RDATA_W = 36
);
    logic                      in_valid;
    logic                      in_ready;
    logic [3:0]                op;
    logic [LANES*DATA_W-1:0]   vdata1;
    logic [LANES*DATA_W-1:0]   vdata2;
    logic [DATA_W-1:0]         data1;
    logic [7:0]                imm;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*DATA_W-1:0]   vdata_out;
    logic [RDATA_W-1:0]        rdata_out;
    logic                      op_err;

    modport master (
        output in_valid, op, vdata1, vdata2, data1, imm, out_ready,
        input  in_ready, out_valid, vdata_out, rdata_out, op_err
    );

    modport slave (
        input  in_valid, op, vdata1, vdata2, data1, imm, out_ready,
        output in_ready, out_valid, vdata_out, rdata_out, op_err
    );
endinterface

// File: rtl/vec_lane_alu.sv
// Single-lane combinational ALU. VDOT reuses the lane multiplier so the
// top-level dot product needs no second set of multipliers.
module vec_lane_alu
    import vec_exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  vec_op_e                  op,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [DATA_W-1:0] s,
    output logic signed [DATA_W-1:0] y
);

    // Lane result; arithmetic wraps mod 2^DATA_W, unused ops give 0.
    always_comb begin
        y = '0;
        case (op)
            VADD:          y = a + b;
            VSUB:          y = a - b;
            VMUL, VDOT:    y = a * b;
            VADDS, VADDI:  y = a + s;
            VMAX:          y = (a > b) ? a : b;
            VMIN:          y = (a < b) ? a : b;
            VSPLAT:        y = s;
            default:       y = '0;
        endcase
    end

endmodule

// File: rtl/vector_execute_pipe.sv
// Pipelined vector execute stage: lane-wise ops, reductions, dot product,
// lane extract and a persistent vector accumulator, LAT cycles deep.
module vector_execute_pipe
    import vec_exec_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int DATA_W  = 32,
    parameter int RDATA_W = 36,
    parameter int LAT     = 2
) (
    input logic                 clk,
    input logic                 rst,
    vector_execute_pipe_if.slave bus
);

    localparam int IDX_W = $clog2(LANES);
    localparam int VEC_W = LANES * DATA_W;

    generate
        if (RDATA_W < DATA_W + IDX_W) begin : g_bad_rdata_w
            $error("RDATA_W too narrow for a LANES-wide reduction");
        end
        if (LANES < 2 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
            $error("LANES must be a power of two >= 2");
        end
        if (LAT < 1) begin : g_bad_lat
            $error("LAT must be >= 1");
        end
    endgenerate

    function automatic logic signed [RDATA_W-1:0] sext_r(input logic signed [DATA_W-1:0] x);
        return RDATA_W'(x);
    endfunction

    function automatic logic signed [DATA_W-1:0] sext_imm(input logic [7:0] x);
        return DATA_W'($signed(x));
    endfunction

    logic    advance;
    logic    accept;
    vec_op_e op_c;

    logic signed [DATA_W-1:0] a_l     [LANES];
    logic signed [DATA_W-1:0] b_l     [LANES];
    logic signed [DATA_W-1:0] y_l     [LANES];
    logic signed [DATA_W-1:0] acc_q   [LANES];
    logic signed [DATA_W-1:0] acc_nxt [LANES];
    logic signed [DATA_W-1:0] scalar_c;
    logic [IDX_W-1:0]         ext_idx;

    logic [VEC_W-1:0]          vres_c;
    logic signed [RDATA_W-1:0] rres_c;
    logic                      err_c;
    logic signed [RDATA_W-1:0] red_sum;
    logic signed [RDATA_W-1:0] dot_sum;

    logic                      vld_p   [LAT];
    logic [VEC_W-1:0]          vdata_p [LAT];
    logic [RDATA_W-1:0]        rdata_p [LAT];
    logic                      err_p   [LAT];

    // The whole chain moves together, so a stalled head blocks new issue.
    assign advance      = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && advance;
    assign bus.in_ready = advance;

    assign op_c     = vec_op_e'(bus.op);
    assign scalar_c = (op_c == VADDI) ? sext_imm(bus.imm) : $signed(bus.data1);
    assign ext_idx  = bus.imm[IDX_W-1:0];

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign a_l[i] = $signed(bus.vdata1[i*DATA_W +: DATA_W]);
            assign b_l[i] = $signed(bus.vdata2[i*DATA_W +: DATA_W]);

            vec_lane_alu #(.DATA_W(DATA_W)) u_alu (
                .op (op_c),
                .a  (a_l[i]),
                .b  (b_l[i]),
                .s  (scalar_c),
                .y  (y_l[i])
            );
        end
    endgenerate

    // Reduction trees: sum of operand lanes and sum of wrapped lane products.
    always_comb begin
        red_sum = '0;
        dot_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            red_sum = red_sum + sext_r(a_l[i]);
            dot_sum = dot_sum + sext_r(y_l[i]);
        end
    end

    // Result and next-accumulator selection for the op presented this cycle.
    always_comb begin
        vres_c = '0;
        rres_c = '0;
        err_c  = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            acc_nxt[i] = acc_q[i];
        end
        case (op_c)
            VADD, VSUB, VMUL, VADDS, VADDI, VMAX, VMIN, VSPLAT: begin
                for (int i = 0; i < LANES; i++) begin
                    vres_c[i*DATA_W +: DATA_W] = y_l[i];
                end
            end
            VREDSUM: rres_c = red_sum;
            VDOT:    rres_c = dot_sum;
            VEXT:    rres_c = RDATA_W'($unsigned(a_l[ext_idx]));
            VACC: begin
                for (int i = 0; i < LANES; i++) begin
                    acc_nxt[i] = acc_q[i] + a_l[i];
                    vres_c[i*DATA_W +: DATA_W] = acc_nxt[i];
                end
            end
            VACCCLR: begin
                for (int i = 0; i < LANES; i++) begin
                    acc_nxt[i] = '0;
                end
            end
            default: err_c = 1'b1;
        endcase
    end

    // Accumulator commits only on a real accept, never while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= acc_nxt[i];
            end
        end
    end

    // Valid+payload shift chain; empty slots carry zero payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < LAT; j++) begin
                vld_p[j]   <= 1'b0;
                vdata_p[j] <= '0;
                rdata_p[j] <= '0;
                err_p[j]   <= 1'b0;
            end
        end else if (advance) begin
            vld_p[0]   <= accept;
            vdata_p[0] <= accept ? vres_c : '0;
            rdata_p[0] <= accept ? rres_c : '0;
            err_p[0]   <= accept ? err_c  : 1'b0;
            for (int j = 1; j < LAT; j++) begin
                vld_p[j]   <= vld_p[j-1];
                vdata_p[j] <= vdata_p[j-1];
                rdata_p[j] <= rdata_p[j-1];
                err_p[j]   <= err_p[j-1];
            end
        end
    end

    assign bus.out_valid = vld_p[LAT-1];
    assign bus.vdata_out = vdata_p[LAT-1];
    assign bus.rdata_out = rdata_p[LAT-1];
    assign bus.op_err    = err_p[LAT-1];

endmodule

// File: tb/tb_vector_execute_pipe.sv
// Bench for vector_execute_pipe (LANES=4, DATA_W=32, RDATA_W=36, LAT=2).
module tb_vector_execute_pipe;
    import vec_exec_pkg::*;

    localparam int LANES = 4, DW = 32, RW = 36, LAT = 2, VW = LANES * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vector_execute_pipe_if #(.LANES(LANES), .DATA_W(DW), .RDATA_W(RW)) bus ();

    vector_execute_pipe #(.LANES(LANES), .DATA_W(DW), .RDATA_W(RW), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]    op;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] d;
        logic [7:0]    imm;
        logic [VW-1:0] ev;
        logic [RW-1:0] er;
        logic          ee;
        string         name;
    } vec_t;

    typedef struct {
        logic [VW-1:0] ev;
        logic [RW-1:0] er;
        logic          ee;
        string         name;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t tv[15];

    function automatic logic [VW-1:0] pk(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [VW-1:0] model_addsub(input logic [3:0] op, input logic [VW-1:0] a, b);
        logic [VW-1:0] r;
        logic [31:0]   x, y;
        for (int i = 0; i < LANES; i++) begin
            x = a[i*DW +: DW];
            y = b[i*DW +: DW];
            r[i*DW +: DW] = (op == VADD) ? x + y : x - y;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard consumer: compares every result the consumer takes.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_vout"}, bus.vdata_out, e.ev);
                chk({e.name, "_rdata"}, VW'(bus.rdata_out), VW'(e.er));
                chk({e.name, "_err"}, VW'(bus.op_err), VW'(e.ee));
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [VW-1:0] a, b, input logic [DW-1:0] d,
                        input logic [7:0] imm, input logic [VW-1:0] ev, input logic [RW-1:0] er,
                        input logic ee, input string name);
        int   n;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.vdata1   = a;
        bus.vdata2   = b;
        bus.data1    = d;
        bus.imm      = imm;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk({name, "_accept_timeout"}, 1'b0, 1'b1);
        end else begin
            e.ev = ev; e.er = er; e.ee = ee; e.name = name;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_v(input vec_t v);
        send(v.op, v.a, v.b, v.d, v.imm, v.ev, v.er, v.ee, v.name);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({name, "_drained"}, VW'(sb.size()), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] ones, twos;
        logic [VW-1:0] ra, rb;
        logic [3:0]    rop;
        ones = pk(1, 1, 1, 1);
        twos = pk(2, 2, 2, 2);

        tv[0]  = '{VADD,    pk(1,2,3,4), pk(10,20,30,40), 0, 0, pk(11,22,33,44), 0, 0, "vadd"};
        tv[1]  = '{VREDSUM, {4{32'hFFFFFFFF}}, 0, 0, 0, 0, 36'hFFFFFFFFC, 0, "redsum_neg"};
        tv[2]  = '{VDOT,    pk(2,3,4,5), ones, 0, 0, 0, 36'd14, 0, "vdot"};
        tv[3]  = '{VEXT,    pk(2,3,4,5), 0, 0, 8'd6, 0, 36'd4, 0, "vext_6"};
        tv[4]  = '{VSUB,    pk(5,5,5,5), pk(1,2,3,6), 0, 0, pk(4,3,2,32'hFFFFFFFF), 0, 0, "vsub"};
        tv[5]  = '{VMUL,    pk(3,32'hFFFFFFFE,32'h10000,7), pk(4,5,32'h10000,32'hFFFFFFFF), 0, 0,
                   pk(12,32'hFFFFFFF6,0,32'hFFFFFFF9), 0, 0, "vmul"};
        tv[6]  = '{VMAX,    pk(32'hFFFFFFFF,5,32'h80000000,0), pk(1,32'hFFFFFFFB,32'h7FFFFFFF,0), 0, 0,
                   pk(1,5,32'h7FFFFFFF,0), 0, 0, "vmax"};
        tv[7]  = '{VMIN,    pk(32'hFFFFFFFF,5,32'h80000000,0), pk(1,32'hFFFFFFFB,32'h7FFFFFFF,0), 0, 0,
                   pk(32'hFFFFFFFF,32'hFFFFFFFB,32'h80000000,0), 0, 0, "vmin"};
        tv[8]  = '{VADDS,   pk(1,2,3,32'hFFFFFFFF), 0, 32'd1, 0, pk(2,3,4,0), 0, 0, "vadds"};
        tv[9]  = '{VADDI,   pk(10,0,0,5), 0, 0, 8'hFE, pk(8,32'hFFFFFFFE,32'hFFFFFFFE,3), 0, 0, "vaddi_neg"};
        tv[10] = '{VSPLAT,  pk(9,9,9,9), 0, 32'hDEADBEEF, 0, {4{32'hDEADBEEF}}, 0, 0, "vsplat"};
        tv[11] = '{VREDSUM, {4{32'h7FFFFFFF}}, 0, 0, 0, 0, 36'h1FFFFFFFC, 0, "redsum_pos"};
        tv[12] = '{VDOT,    {4{32'hFFFFFFFF}}, pk(1,2,3,4), 0, 0, 0, 36'hFFFFFFFF6, 0, "vdot_neg"};
        tv[13] = '{VEXT,    pk(2,3,4,5), 0, 0, 8'hFF, 0, 36'd5, 0, "vext_ff"};
        tv[14] = '{4'hD,    pk(1,2,3,4), pk(1,2,3,4), 32'd1, 8'd1, 0, 0, 1'b1, "illegal_d"};

        bus.in_valid = 1'b0; bus.op = '0; bus.vdata1 = '0; bus.vdata2 = '0;
        bus.data1 = '0; bus.imm = '0; bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", VW'(bus.out_valid), '0);
        chk("rst_vdata_out", bus.vdata_out, '0);
        chk("rst_rdata_out", VW'(bus.rdata_out), '0);
        chk("rst_op_err",    VW'(bus.op_err), '0);
        chk("rst_in_ready",  VW'(bus.in_ready), VW'(1));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency: result appears LAT edges after the accepting edge
        send_v(tv[0]);
        chk("lat_not_early", VW'(bus.out_valid), '0);
        @(posedge clk);
        #1;
        chk("lat_on_time", VW'(bus.out_valid), VW'(1));
        drain("lat");

        // Table vectors back-to-back
        for (int i = 0; i < 15; i++) send_v(tv[i]);
        drain("table");

        // Accumulator clear then three back-to-back VACCs
        send(VACCCLR, pk(7,7,7,7), 0, 0, 0, 0, 0, 0, "accclr");
        send(VACC, ones, 0, 0, 0, ones,            0, 0, "vacc_1");
        send(VACC, ones, 0, 0, 0, twos,            0, 0, "vacc_2");
        send(VACC, ones, 0, 0, 0, pk(3,3,3,3),     0, 0, "vacc_3");
        drain("acc");

        // Back-pressure: fill the chain, hold five cycles with a VACC waiting
        bus.out_ready = 1'b0;
        send(VADD, ones, ones, 0, 0, twos,         0, 0, "stall_a");
        send(VADD, twos, twos, 0, 0, pk(4,4,4,4),  0, 0, "stall_b");
        fork
            begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk("stall_in_ready",  VW'(bus.in_ready), '0);
                    chk("stall_out_valid", VW'(bus.out_valid), VW'(1));
                    chk("stall_hold",      bus.vdata_out, twos);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
            send(VACC, pk(5,5,5,5), 0, 0, 0, pk(8,8,8,8), 0, 0, "stall_vacc");
        join
        send(VACC, ones, 0, 0, 0, pk(9,9,9,9), 0, 0, "vacc_once");
        drain("stall");

        // Random add/sub stream under random back-pressure
        fork
            for (int k = 0; k < 24; k++) begin
                rop = ($urandom_range(0, 1) == 0) ? VADD : VSUB;
                ra  = {$urandom, $urandom, $urandom, $urandom};
                rb  = {$urandom, $urandom, $urandom, $urandom};
                send(rop, ra, rb, 0, 0, model_addsub(rop, ra, rb), 0, 0, "rand");
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 1) == 1);
                end
                bus.out_ready = 1'b1;
            end
        join
        bus.out_ready = 1'b1;
        drain("rand");

        // Reset with two ops in flight drops them and clears acc
        bus.out_ready = 1'b0;
        send(VADD, ones, ones, 0, 0, twos, 0, 0, "flight_a");
        send(VADD, ones, ones, 0, 0, twos, 0, 0, "flight_b");
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        chk("midrst_out_valid", VW'(bus.out_valid), '0);
        chk("midrst_vdata",     bus.vdata_out, '0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        send(VACC, pk(7,7,7,7), 0, 0, 0, pk(7,7,7,7), 0, 0, "acc_after_rst");
        send(4'hF, ones, ones, 32'd3, 8'd2, 0, 0, 1'b1, "illegal_f");
        send(VACC, ones, 0, 0, 0, pk(8,8,8,8), 0, 0, "acc_after_illegal");
        drain("final");
        @(posedge clk);
        #1;
        chk("idle_out_valid", VW'(bus.out_valid), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
